// File: rtl/simd_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simd_pipe_pkg
// Description : Shared defaults, NOP encoding, rd field position and the
//               EX->WB entry type for the SIMD execute/writeback boundary.
// Revision    : 1.0 - initial release
// ============================================================================
package simd_pipe_pkg;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_INSTR_W = 25;

  // Encoding that never writes the register file: 2'b11 then all zeros.
  localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = {2'b11, 23'd0};

  // Destination register field inside the instruction word.
  localparam int RD_LSB = 0;
  localparam int RD_MSB = 4;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_DATA_W-1:0]  data;
  } ex_wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-slot (main + skid) valid/ready register. Fully registered
//               in both directions: in_ready depends only on the skid flag and
//               no input reaches an output combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
  import simd_pipe_pkg::*;
#(
  parameter type T = ex_wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_entry,
  output logic out_valid,
  input  logic out_ready,
  output T     out_entry
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     main_q, main_d;
  T     skid_q, skid_d;

  logic in_fire;
  logic out_fire;

  // The skid slot only fills while main is stalled, so an empty skid means
  // there is always room for one more entry.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_entry = main_q;

  assign in_fire  = in_valid & ~skid_valid_q & ~flush;
  assign out_fire = main_valid_q & out_ready;

  // Next-state: refill main from skid first (older entry), else from input.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush) begin
      // Data is left untouched; only the valid flags are dropped.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = in_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Main is stalled and skid is empty (otherwise in_fire is low).
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ex_wb_stage_pipe
// Description : EX->WB pipeline boundary for the SIMD datapath. Buffers EX
//               results in a two-slot skid register, decodes the register
//               file write strobe, exposes a forwarding tap and counts
//               committed writes with a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_wb_stage_pipe #(
  parameter int                 DATA_W    = simd_pipe_pkg::DEF_DATA_W,
  parameter int                 INSTR_W   = simd_pipe_pkg::DEF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = simd_pipe_pkg::NOP_INSTR,
  parameter int                 CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [INSTR_W-1:0] ex_instr,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               flush,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [INSTR_W-1:0] wb_instr,
  output logic [4:0]         wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               wb_we,
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic [CNT_W-1:0]   wr_count
);

  import simd_pipe_pkg::*;

  // Local entry type so non-default widths still pack correctly.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t in_entry;
  entry_t main_entry;
  logic   is_nop;

  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  assign in_entry.instr = ex_instr;
  assign in_entry.data  = ex_data;

  pipe_skid_reg #(
    .T (entry_t)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_entry  (in_entry),
    .out_valid (wb_valid),
    .out_ready (wb_ready),
    .out_entry (main_entry)
  );

  assign wb_instr = main_entry.instr;
  assign wb_data  = main_entry.data;
  assign wb_rd    = main_entry.instr[RD_MSB:RD_LSB];
  assign is_nop   = (main_entry.instr == NOP_INSTR);

  // A flushed entry must never reach the register file, even if consumed.
  assign wb_we = wb_valid & wb_ready & ~flush & ~is_nop;

  assign fwd_valid = wb_valid & ~is_nop;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;

  // Saturating committed-write counter; flush leaves it alone.
  always_comb begin
    wr_count_d = wr_count_q;
    if (wb_we && (wr_count_q != {CNT_W{1'b1}})) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_wb_stage_pipe
// Description : Self-checking bench for ex_wb_stage_pipe: directed scenarios
//               plus a random valid/ready/flush stream against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_wb_stage_pipe;

  localparam logic [24:0] NOP = {2'b11, 23'd0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ex_valid, ex_ready, flush;
  logic [24:0]  ex_instr;
  logic [127:0] ex_data;
  logic         wb_valid, wb_ready, wb_we, fwd_valid;
  logic [24:0]  wb_instr;
  logic [4:0]   wb_rd, fwd_rd;
  logic [127:0] wb_data, fwd_data;
  logic [31:0]  wr_count;

  // Narrow-counter instance for saturation checking.
  logic         c_valid, c_ready_in, c_ready, c_wb_valid, c_wb_we, c_fwd_valid;
  logic [24:0]  c_wb_instr;
  logic [4:0]   c_wb_rd, c_fwd_rd;
  logic [127:0] c_wb_data, c_fwd_data;
  logic [3:0]   c_wr_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [24:0]  instr;
    logic [127:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mcnt;

  always #5 clk = ~clk;

  ex_wb_stage_pipe dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_data(ex_data), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_instr(wb_instr),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wr_count(wr_count)
  );

  ex_wb_stage_pipe #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .ex_valid(c_valid), .ex_ready(c_ready),
    .ex_instr(25'd3), .ex_data(128'h1), .flush(1'b0),
    .wb_valid(c_wb_valid), .wb_ready(c_ready_in), .wb_instr(c_wb_instr),
    .wb_rd(c_wb_rd), .wb_data(c_wb_data), .wb_we(c_wb_we),
    .fwd_valid(c_fwd_valid), .fwd_rd(c_fwd_rd), .fwd_data(c_fwd_data),
    .wr_count(c_wr_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [24:0] ins, input logic [127:0] d,
                       input logic r, input logic f);
    ex_valid = v; ex_instr = ins; ex_data = d; wb_ready = r; flush = f;
    #1;
  endtask

  // Compare every output with the queue model before the coming edge.
  task automatic check_model();
    logic exp_we;
    chk("ex_ready", ex_ready, mq.size() < 2);
    chk("wb_valid", wb_valid, mq.size() > 0);
    chk("wr_count", wr_count, mcnt);
    if (mq.size() > 0) begin
      exp_we = wb_ready && !flush && (mq[0].instr != NOP);
      chk("wb_instr", wb_instr, mq[0].instr);
      chk("wb_data", wb_data, mq[0].data);
      chk("wb_rd", wb_rd, mq[0].instr[4:0]);
      chk("wb_we", wb_we, exp_we);
      chk("fwd_valid", fwd_valid, mq[0].instr != NOP);
      chk("fwd_data", fwd_data, mq[0].data);
    end else begin
      chk("wb_we_idle", wb_we, 1'b0);
      chk("fwd_valid_idle", fwd_valid, 1'b0);
    end
  endtask

  // Apply the clock edge to the model, then step the DUT.
  task automatic advance();
    bit fo, fi;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      mcnt = 0;
    end else begin
      fo = (mq.size() > 0) && wb_ready;
      fi = ex_valid && (mq.size() < 2) && !flush;
      if (flush) begin
        mq.delete();
      end else begin
        if (fo) begin
          if (mq[0].instr != NOP && mcnt != 32'hFFFF_FFFF) mcnt++;
          void'(mq.pop_front());
        end
        if (fi) begin
          e.instr = ex_instr;
          e.data  = ex_data;
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic v, input logic [24:0] ins, input logic [127:0] d,
                       input logic r, input logic f);
    drive(v, ins, d, r, f);
    check_model();
    advance();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [24:0] ri;
    rst_n = 1'b0; c_valid = 1'b0; c_ready_in = 1'b0;
    drive(0, 0, 0, 0, 0);
    advance();
    advance();
    rst_n = 1'b1;

    // Reset state.
    drive(0, 0, 0, 0, 0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_ex_ready", ex_ready, 1'b1);
    chk("rst_wb_instr", wb_instr, 25'd0);
    chk("rst_wb_data", wb_data, 128'd0);
    chk("rst_wr_count", wr_count, 32'd0);

    // Single op: one-cycle latency, write strobe, count 1.
    cycle(1, 25'h0000003, {16{8'hA5}}, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("single_valid", wb_valid, 1'b1);
    chk("single_rd", wb_rd, 5'd3);
    chk("single_we", wb_we, 1'b1);
    check_model();
    advance();
    chk("single_count", wr_count, 32'd1);

    // NOP never writes.
    cycle(1, NOP, 128'h1234, 1, 0);
    drive(0, 0, 0, 1, 0);
    chk("nop_valid", wb_valid, 1'b1);
    chk("nop_we", wb_we, 1'b0);
    chk("nop_fwd", fwd_valid, 1'b0);
    advance();
    chk("nop_count", wr_count, 32'd1);

    // Backpressure: A then B held, then drained in order.
    cycle(1, 25'h05, 128'hAAAA, 0, 0);
    cycle(1, 25'h06, 128'hBBBB, 0, 0);
    drive(1, 25'h07, 128'hCCCC, 0, 0);
    chk("bp_ready_low", ex_ready, 1'b0);
    check_model();
    advance();
    drive(0, 0, 0, 1, 0);
    chk("bp_first_rd", wb_rd, 5'd5);
    chk("bp_first_we", wb_we, 1'b1);
    check_model();
    advance();
    drive(0, 0, 0, 1, 0);
    chk("bp_second_rd", wb_rd, 5'd6);
    chk("bp_second_data", wb_data, 128'hBBBB);
    chk("bp_second_we", wb_we, 1'b1);
    check_model();
    advance();
    chk("bp_count", wr_count, 32'd3);

    // Flush with both slots full.
    cycle(1, 25'h08, 128'h8, 0, 0);
    cycle(1, 25'h09, 128'h9, 0, 0);
    drive(1, 25'h0A, 128'hA, 1, 1);
    chk("flush_we", wb_we, 1'b0);
    check_model();
    advance();
    drive(0, 0, 0, 0, 0);
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_ready", ex_ready, 1'b1);
    chk("flush_count", wr_count, 32'd3);

    // Random stream against the queue model.
    for (int n = 0; n < 400; n++) begin
      ri = ($urandom_range(0, 5) == 0) ? NOP : 25'($urandom);
      cycle($urandom_range(0, 3) != 0, ri, rnd128(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
    end

    // Reset during a stalled stream.
    cycle(1, 25'h11, 128'h11, 0, 0);
    cycle(1, 25'h12, 128'h12, 0, 0);
    rst_n = 1'b0;
    cycle(1, 25'h13, 128'h13, 0, 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("midrst_valid", wb_valid, 1'b0);
    chk("midrst_ready", ex_ready, 1'b1);
    chk("midrst_instr", wb_instr, 25'd0);
    chk("midrst_data", wb_data, 128'd0);
    chk("midrst_count", wr_count, 32'd0);
    chk("midrst_fwd", fwd_valid, 1'b0);

    // Second random burst after reset.
    for (int n = 0; n < 200; n++) begin
      ri = ($urandom_range(0, 5) == 0) ? NOP : 25'($urandom);
      cycle($urandom_range(0, 3) != 0, ri, rnd128(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0);
    end

    // Saturation on the 4-bit counter: after k edges, k-1 writes.
    drive(0, 0, 0, 0, 0);
    c_valid = 1'b1; c_ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    chk("cnt4_mid", c_wr_count, 4'd9);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
    end
    chk("cnt4_full", c_wr_count, 4'hF);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
    end
    chk("cnt4_sat", c_wr_count, 4'hF);
    chk("cnt4_we_still", c_wb_we, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_wb_stage_pipe.md
EX_WB_STAGE_PIPE -- requirements
Module: ex_wb_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 128, SIMD result width in bits.
REQ-002 Parameter INSTR_W, default 25, instruction field width; rd = instr[4:0].
REQ-003 Parameter NOP_INSTR, default 25'b11 followed by 23 zeros, encoding that never writes back.
REQ-004 Parameter CNT_W, default 32, retired-write counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 ex_valid  input  1  EX presents a result.
REQ-008 ex_ready  output  1  stage can accept; driven only from registered state.
REQ-009 ex_instr  input  INSTR_W  instruction field from EX.
REQ-010 ex_data  input  DATA_W  result from EX.
REQ-011 flush  input  1  kill all held and incoming entries.
REQ-012 wb_valid  output  1  WB entry present.
REQ-013 wb_ready  input  1  WB/register file consumes the entry.
REQ-014 wb_instr  output  INSTR_W  held instruction field.
REQ-015 wb_rd  output  5  destination register, wb_instr[4:0].
REQ-016 wb_data  output  DATA_W  held result.
REQ-017 wb_we  output  1  register-file write strobe.
REQ-018 fwd_valid, fwd_rd (5), fwd_data (DATA_W)  output  forwarding tap to EX operand mux.
REQ-019 wr_count  output  CNT_W  number of committed writes.

Function
REQ-020 Two storage slots: main (drives wb_*) and skid; no combinational path ex_* to wb_* or wb_ready to ex_ready.
REQ-021 ex_ready = NOT skid_valid (registered).
REQ-022 Input fire = ex_valid AND ex_ready AND NOT flush; output fire = wb_valid AND wb_ready.
REQ-023 Main empty or output fire: main loads skid if skid_valid (skid cleared), else loads input on input fire, else main empties.
REQ-024 Main held (wb_valid AND NOT wb_ready) and input fire: input captured in skid; ex_ready low next cycle.
REQ-025 Order preserved: entries leave in acceptance order; no loss, no duplication.
REQ-026 Latency: input fire with both slots empty -> wb_valid high next cycle.
REQ-027 Sustained throughput one entry per cycle when wb_ready held high.
REQ-028 wb_we = output fire AND wb_instr != NOP_INSTR (combinational from registered state and wb_ready).
REQ-029 fwd_valid = wb_valid AND wb_instr != NOP_INSTR; fwd_rd/fwd_data mirror main slot.
REQ-030 flush: both slots invalid next cycle; wb_we forced 0 in flush cycle; ex_ready high next cycle; concurrent input dropped.
REQ-031 wr_count increments by 1 per wb_we cycle, saturates at all-ones (no wrap).
REQ-032 flush does not clear wr_count.
REQ-033 Data fields of invalid slots are don't-care to consumers but shall not change while valid and stalled.

Reset
REQ-034 rst_n low at clock edge: main/skid valid 0, wb_instr/wb_data 0, wr_count 0, ex_ready 1 next cycle.
REQ-035 Reset mid-transfer discards all entries; reset has priority over flush and handshakes.

Structure
REQ-036 Package simd_pipe_pkg holds NOP_INSTR, DATA_W/INSTR_W defaults, RD_LSB/RD_MSB, typedef ex_wb_entry_t {instr, data}.
REQ-037 One sub-module pipe_skid_reg (generic two-slot valid/ready register of ex_wb_entry_t); WE decode, forwarding and counter in top.

Verification
REQ-038 Single op: instr 25'h0000003, data 128'hA5.., wb_ready 1 -> next cycle wb_valid 1, wb_rd 3, wb_we 1, wr_count 1.
REQ-039 NOP: ex_instr = NOP_INSTR -> wb_valid 1, wb_we 0, fwd_valid 0, wr_count unchanged.
REQ-040 Backpressure: wb_ready 0, send A,B -> ex_ready 0 after B; release wb_ready -> A then B in order, 2 wb_we pulses.
REQ-041 Flush with both slots full -> next cycle wb_valid 0, ex_ready 1, no wb_we.
REQ-042 Counter: preload via 2^CNT_W writes (CNT_W=4 build) -> wr_count holds 4'hF.
REQ-043 rst_n low during stalled stream -> all outputs reset values next cycle; random valid/ready stream vs. queue scoreboard.
